// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants and state type for the UART receive path
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int DEFAULT_SAMPLE_POINT = 7;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

endpackage

// File: rtl/bit_sample_counter.sv
// rtl/bit_sample_counter.sv - oversampling position counter within one bit period
module bit_sample_counter
  import uart_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] count_o
);

  // Held at zero while disabled so every frame starts counting from bit phase 0.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_o <= '0;
    end else if (!en_i) begin
      count_o <= '0;
    end else begin
      count_o <= count_o + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receive sequencer with mid-bit sampling and valid/ready output
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int SAMPLE_POINT = DEFAULT_SAMPLE_POINT
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 rx_i,
  input  logic                 ready_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 valid_o,
  output logic                 frame_err_o,
  output logic                 overrun_o,
  output logic                 busy_o
);

  localparam int IDX_W = $clog2(DATA_BITS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);
  localparam logic [CNT_W-1:0] SAMPLE_CNT = CNT_W'(SAMPLE_POINT);

  logic                 rx_meta;
  logic                 rx_s;
  rx_state_t            state;
  logic [DATA_BITS-1:0] shift;
  logic [IDX_W-1:0]     bit_idx;
  logic [CNT_W-1:0]     count;
  logic                 cnt_en;
  logic                 sample;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rx_s    <= rx_meta;
    end
  end

  // Counter runs continuously across START/DATA/STOP so samples stay 16 clocks apart.
  assign cnt_en = (state == START) || (state == DATA) || (state == STOP);
  assign sample = (count == SAMPLE_CNT);

  bit_sample_counter u_counter (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (cnt_en),
    .count_o(count)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      shift       <= '0;
      bit_idx     <= '0;
      data_o      <= '0;
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
      if (valid_o && ready_i) begin
        valid_o <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state  <= START;
            busy_o <= 1'b1;
          end
        end
        START: begin
          if (sample) begin
            if (!rx_s) begin
              state   <= DATA;
              bit_idx <= '0;
            end else begin
              state  <= IDLE;
              busy_o <= 1'b0;
            end
          end
        end
        DATA: begin
          if (sample) begin
            shift   <= {rx_s, shift[DATA_BITS-1:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == LAST_IDX) begin
              state <= STOP;
            end
          end
        end
        STOP: begin
          if (sample) begin
            if (rx_s) begin
              // A word still pending and not taken this cycle is lost to the new one.
              data_o    <= shift;
              valid_o   <= 1'b1;
              overrun_o <= valid_o && !ready_i;
              state     <= IDLE;
              busy_o    <= 1'b0;
            end else begin
              frame_err_o <= 1'b1;
              state       <= BREAK;
            end
          end
        end
        BREAK: begin
          if (rx_s) begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - scoreboard bench for uart_rx_ctrl (8-bit and 5-bit instances)
module tb_uart_rx_ctrl;

  localparam int ACC  = 0;
  localparam int OVR  = 1;
  localparam int FERR = 2;
  localparam int LAT8 = 8 + 16 * (8 + 1);
  localparam int LAT5 = 8 + 16 * (5 + 1);

  typedef struct {
    int         kind;
    logic [7:0] data;
  } evt_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx8 = 1'b1;
  logic       rx5 = 1'b1;
  logic       ready8 = 1'b0;
  logic       ready5 = 1'b1;
  logic [7:0] data8;
  logic [4:0] data5;
  logic       valid8, ferr8, ovr8, busy8;
  logic       valid5, ferr5, ovr5, busy5;

  int checks = 0;
  int errors = 0;

  evt_t       q8[$];
  logic [4:0] q5[$];
  logic       pending = 1'b0;
  logic [7:0] pending_data = '0;
  logic [7:0] last_word = '0;

  always #5 clk = ~clk;

  uart_rx_ctrl #(.DATA_BITS(8)) dut8 (
    .clk_i(clk), .rst_i(rst), .rx_i(rx8), .ready_i(ready8), .data_o(data8),
    .valid_o(valid8), .frame_err_o(ferr8), .overrun_o(ovr8), .busy_o(busy8)
  );

  uart_rx_ctrl #(.DATA_BITS(5)) dut5 (
    .clk_i(clk), .rst_i(rst), .rx_i(rx5), .ready_i(ready5), .data_o(data5),
    .valid_o(valid5), .frame_err_o(ferr5), .overrun_o(ovr5), .busy_o(busy5)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_bit(input int sel, input logic b, input int clocks);
    if (sel == 0) rx8 = b;
    else rx5 = b;
    tick(clocks);
  endtask

  task automatic send_frame(input int sel, input logic [7:0] d, input int nbits, input logic stop);
    drive_bit(sel, 1'b0, 16);
    for (int i = 0; i < nbits; i++) drive_bit(sel, d[i], 16);
    drive_bit(sel, stop, 16);
  endtask

  task automatic set_ready(input logic r);
    ready8 = r;
    if (r && pending) begin
      q8.push_back('{ACC, pending_data});
      pending = 1'b0;
    end
  endtask

  // Frame-level model: the outcome depends only on stop bit, ready and whether a word is pending.
  task automatic frame8(input logic [7:0] d, input logic ok);
    if (ok) begin
      if (ready8) begin
        q8.push_back('{ACC, d});
      end else begin
        if (pending) q8.push_back('{OVR, d});
        pending      = 1'b1;
        pending_data = d;
      end
      last_word = d;
    end else begin
      q8.push_back('{FERR, last_word});
    end
    send_frame(0, d, 8, ok);
  endtask

  task automatic frame5(input logic [4:0] d);
    q5.push_back(d);
    send_frame(1, {3'b000, d}, 5, 1'b1);
  endtask

  task automatic pop8(input string name, input int kind, input logic [7:0] d);
    evt_t e;
    if (q8.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_%s: got data %0h expected no event", name, d);
    end else begin
      e = q8.pop_front();
      chk({name, "_kind"}, kind, e.kind);
      chk({name, "_data"}, int'(d), int'(e.data));
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (ferr8 && ovr8) chk("ferr_ovr_exclusive", 1, 0);
      if (ovr8) pop8("overrun", OVR, data8);
      if (ferr8) pop8("frame_err", FERR, data8);
      if (valid8 && ready8) pop8("accept", ACC, data8);
      if (ferr5 || ovr5) chk("dut5_no_error", 1, 0);
      if (valid5 && ready5) begin
        if (q5.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_accept5: got %0h expected no event", data5);
        end else begin
          chk("accept5_data", int'(data5), int'(q5.pop_front()));
        end
      end
    end
  end

  int   lat8 = 0, lat5 = 0;
  logic busy8_q = 1'b0, valid8_q = 1'b0, busy5_q = 1'b0, valid5_q = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      busy8_q  = 1'b0;
      valid8_q = 1'b0;
      busy5_q  = 1'b0;
      valid5_q = 1'b0;
    end else begin
      if (busy8 && !busy8_q) lat8 = 0;
      else lat8++;
      if (busy5 && !busy5_q) lat5 = 0;
      else lat5++;
      if ((valid8 && !valid8_q) || ovr8) chk("latency8", lat8, LAT8);
      if (valid5 && !valid5_q) chk("latency5", lat5, LAT5);
      busy8_q  = busy8;
      valid8_q = valid8;
      busy5_q  = busy5;
      valid5_q = valid5;
    end
  end

  initial begin
    logic [7:0] d;
    int         hold;

    tick(3);
    chk("reset_data8", int'(data8), 0);
    chk("reset_valid8", int'(valid8), 0);
    chk("reset_ferr8", int'(ferr8), 0);
    chk("reset_ovr8", int'(ovr8), 0);
    chk("reset_busy8", int'(busy8), 0);
    chk("reset_valid5", int'(valid5), 0);
    rst = 1'b0;
    tick(4);

    set_ready(1'b1);
    frame8(8'hA5, 1'b1);
    chk("busy_after_a5", int'(busy8), 0);

    drive_bit(0, 1'b0, 4);
    drive_bit(0, 1'b1, 20);
    chk("busy_after_glitch", int'(busy8), 0);

    frame8(8'h3C, 1'b0);
    drive_bit(0, 1'b0, 40);
    chk("busy_in_break", int'(busy8), 1);
    drive_bit(0, 1'b1, 6);
    chk("busy_after_break", int'(busy8), 0);
    frame8(8'h81, 1'b1);

    set_ready(1'b0);
    frame8(8'h11, 1'b1);
    frame8(8'h22, 1'b1);
    chk("overrun_valid", int'(valid8), 1);
    chk("overrun_data", int'(data8), 8'h22);
    set_ready(1'b1);
    tick(1);
    chk("valid_cleared_by_ready", int'(valid8), 0);

    set_ready(1'b0);
    frame8(8'h77, 1'b1);
    drive_bit(0, 1'b0, 16);
    for (int i = 0; i < 4; i++) drive_bit(0, 1'b1, 16);
    #2 rst = 1'b1;
    #1;
    chk("midreset_valid", int'(valid8), 0);
    chk("midreset_data", int'(data8), 0);
    chk("midreset_busy", int'(busy8), 0);
    chk("midreset_ferr", int'(ferr8), 0);
    pending   = 1'b0;
    last_word = '0;
    rx8       = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(4);
    set_ready(1'b1);
    frame8(8'h5A, 1'b1);

    frame5(5'h15);
    for (int i = 0; i < 6; i++) begin
      frame5(5'($urandom_range(0, 31)));
      drive_bit(1, 1'b1, $urandom_range(0, 12));
    end

    for (int i = 0; i < 40; i++) begin
      set_ready(1'($urandom_range(0, 1)));
      d = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) begin
        hold = $urandom_range(0, 40);
        frame8(d, 1'b0);
        drive_bit(0, 1'b0, hold);
        drive_bit(0, 1'b1, 4);
      end else begin
        frame8(d, 1'b1);
      end
      drive_bit(0, 1'b1, $urandom_range(0, 20));
    end
    set_ready(1'b1);

    tick(40);
    chk("q8_drained", q8.size(), 0);
    chk("q5_drained", q5.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
